irq_controller: RTL



---
 rtl/irq_pkg.sv | 25 ++
 rtl/irq_edge_detect.sv | 29 ++
 rtl/irq_controller.sv | 89 ++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// Shared constants for the interrupt controller: source bit positions,
// default MMIO addresses and the implemented-bit mask helper.
package irq_pkg;

    localparam int IRQ_VBLANK = 0;
    localparam int IRQ_STAT   = 1;
    localparam int IRQ_TIMER  = 2;
    localparam int IRQ_SERIAL = 3;
    localparam int IRQ_JOYPAD = 4;

    localparam logic [15:0] IF_ADDR_DEF = 16'hFF0F;
    localparam logic [15:0] IE_ADDR_DEF = 16'hFFFF;

    // Bits of IF that do not exist read back as 1.
    localparam logic [7:0] IF_RD_MASK = 8'hE0;

    function automatic logic [7:0] impl_mask(input int n);
        logic [7:0] m;
        for (int i = 0; i < 8; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/irq_edge_detect.sv
// Rising-edge detector for the request lines; edges are combinational, one
// cycle wide. No backpressure. prev tracks REQ even in reset.
module irq_edge_detect #(
    parameter int W = 5
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] req_i,
    output logic [W-1:0] edge_o
);

    logic [W-1:0] prev_q;
    logic [W-1:0] prev_d;

    assign prev_d = req_i;

    // Loading prev from the live lines during reset means a line already
    // high at release is treated as old news, not as a fresh request.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= req_i;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign edge_o = req_i & ~prev_q & {W{~rst_i}};

endmodule

// File: rtl/irq_controller.sv
// IF/IE interrupt register file feeding the SM83 core: edge-captured requests
// show on CPU_IRQ_TRIG/WAKE one cycle after the edge; reads land in DOUT next cycle.
module irq_controller
    import irq_pkg::*;
#(
    parameter int          NUM_SRC = 5,
    parameter logic [15:0] IF_ADDR = IF_ADDR_DEF,
    parameter logic [15:0] IE_ADDR = IE_ADDR_DEF
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [NUM_SRC-1:0] REQ,
    input  logic [15:0]        A,
    input  logic [7:0]         DIN,
    input  logic               WR,
    input  logic               RD,
    output logic [7:0]         DOUT,
    output logic               SEL,
    output logic [7:0]         CPU_IRQ_TRIG,
    input  logic [7:0]         CPU_IRQ_ACK,
    output logic               WAKE
);

    localparam logic [7:0] IMPL_MASK = impl_mask(NUM_SRC);

    logic [NUM_SRC-1:0] req_edge;
    logic               hit_if;
    logic               hit_ie;
    logic [7:0]         if_q, if_d;
    logic [7:0]         ie_q, ie_d;
    logic [7:0]         dout_q, dout_d;

    irq_edge_detect #(
        .W (NUM_SRC)
    ) u_edge_detect (
        .clk_i  (CLK),
        .rst_i  (RESET),
        .req_i  (REQ),
        .edge_o (req_edge)
    );

    assign hit_if = (A == IF_ADDR);
    assign hit_ie = (A == IE_ADDR);

    // Write, then ack, then edge: a fresh edge always survives the cycle.
    always_comb begin
        if_d = if_q;
        if (WR && hit_if) begin
            if_d = DIN;
        end
        if_d = if_d & ~CPU_IRQ_ACK;
        if_d = if_d | 8'(req_edge);
        if_d = if_d & IMPL_MASK;

        ie_d = ie_q;
        if (WR && hit_ie) begin
            ie_d = DIN;
        end

        dout_d = dout_q;
        if (RD) begin
            if (hit_if) begin
                dout_d = if_q | ~IMPL_MASK;
            end else if (hit_ie) begin
                dout_d = ie_q;
            end else begin
                dout_d = '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            if_q   <= '0;
            ie_q   <= '0;
            dout_q <= '0;
        end else begin
            if_q   <= if_d;
            ie_q   <= ie_d;
            dout_q <= dout_d;
        end
    end

    assign DOUT         = dout_q;
    assign SEL          = hit_if | hit_ie;
    assign CPU_IRQ_TRIG = if_q & ie_q & IMPL_MASK;
    assign WAKE         = |CPU_IRQ_TRIG;

endmodule
